// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control/handshake bundle between the core datapath and instr_sequencer
// The step input exists only when SEQ_SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_req;
  logic [3:0]       opcode;
  logic             reg_wr_dec;
  logic             jump_dec;
  logic             jal_dec;
  logic             imem_ready;
  logic             dmem_ready;
  logic             alu_done;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
`endif
  logic             imem_req;
  logic             ir_load;
  logic             alu_start;
  logic             dmem_rd_en;
  logic             dmem_wr_en;
  logic             rf_wr_en;
  logic             pc_en;
  logic             pc_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] retire_cnt;
  logic             err;

  modport master (
    output start, halt_req, opcode, reg_wr_dec, jump_dec, jal_dec,
           imem_ready, dmem_ready, alu_done,
    input  imem_req, ir_load, alu_start, dmem_rd_en, dmem_wr_en, rf_wr_en,
           pc_en, pc_sel, state, retire_cnt, err
`ifdef SEQ_SINGLE_STEP_EN
    , output step
`endif
  );

  modport slave (
    input  start, halt_req, opcode, reg_wr_dec, jump_dec, jal_dec,
           imem_ready, dmem_ready, alu_done,
    output imem_req, ir_load, alu_start, dmem_rd_en, dmem_wr_en, rf_wr_en,
           pc_en, pc_sel, state, retire_cnt, err
`ifdef SEQ_SINGLE_STEP_EN
    , input step
`endif
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit RISC core
// Define SEQ_SINGLE_STEP_EN to park in IDLE after every retire until start or step.
module instr_sequencer #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             err_q, err_d;

  logic is_alu, is_ld, is_st, go, park, retire;

  assign is_alu = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
  assign is_ld  = (bus.opcode == OP_LD);
  assign is_st  = (bus.opcode == OP_ST);

`ifdef SEQ_SINGLE_STEP_EN
  assign go   = bus.start | bus.step;
  assign park = 1'b1;
`else
  assign go   = bus.start;
  assign park = bus.halt_req;
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retire_d = retire_q;
    err_d    = err_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE:   if (go) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready)          state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                         wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        if (bus.opcode == OP_NOP) retire  = 1'b1;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!is_alu || bus.alu_done)  state_d = (is_ld || is_st) ? S_MEM : S_WB;
        else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                          wait_d  = wait_q + 8'd1;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (is_st) retire  = 1'b1;
          else       state_d = S_WB;
        end else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                              wait_d  = wait_q + 8'd1;
      end
      S_WB:     retire = 1'b1;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
    if (retire) begin
      retire_d = retire_q + CNT_W'(1);
      state_d  = park ? S_IDLE : S_FETCH;
    end
    // The wait counter measures time spent in one state only.
    if (state_d != state_q) wait_d = '0;
    if (state_d == S_ERR)   err_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      retire_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
      err_q    <= err_d;
    end
  end

  // Enables are qualified by the registered state so none can leak outside its state.
  assign bus.imem_req   = (state_q == S_FETCH);
  assign bus.ir_load    = (state_q == S_FETCH) && bus.imem_ready;
  assign bus.alu_start  = (state_q == S_EXEC) && is_alu && (wait_q == '0);
  assign bus.dmem_rd_en = (state_q == S_MEM) && is_ld;
  assign bus.dmem_wr_en = (state_q == S_MEM) && is_st;
  assign bus.rf_wr_en   = (state_q == S_WB) && bus.reg_wr_dec && !is_st;
  assign bus.pc_en      = ((state_q == S_DECODE) && (bus.opcode == OP_NOP)) ||
                          (state_q == S_WB) ||
                          ((state_q == S_MEM) && is_st && bus.dmem_ready);
  assign bus.pc_sel     = (state_q == S_WB) && (bus.jump_dec || bus.jal_dec);
  assign bus.state      = state_q;
  assign bus.retire_cnt = retire_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized bench for instr_sequencer against a per-instruction cycle-trace model
module tb_instr_sequencer;
  localparam int TO = 15;
  localparam int CW = 4;
`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  localparam logic [7:0] E_IREQ = 8'h80, E_IRL = 8'h40, E_ALU = 8'h20, E_RD = 8'h10;
  localparam logic [7:0] E_WR = 8'h08, E_RF = 8'h04, E_PC = 8'h02, E_SEL = 8'h01;

  typedef struct {
    logic [2:0] st;
    logic [7:0] en;
    logic ir, dr, ad, halt, start;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(CW)) bus ();
  instr_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  cyc_t q[$];
  logic [CW-1:0] exp_cnt;
  logic in_idle;
  logic cur_hlt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] en_vec();
    return {bus.imem_req, bus.ir_load, bus.alu_start, bus.dmem_rd_en,
            bus.dmem_wr_en, bus.rf_wr_en, bus.pc_en, bus.pc_sel};
  endfunction

  // Inputs irrelevant to a state get random values; relevant ones come from the trace.
  function automatic void push(input logic [2:0] st, input logic [7:0] en,
                               input logic ir, input logic dr, input logic ad,
                               input logic rt, input logic stt);
    cyc_t c;
    c.st    = st;
    c.en    = en;
    c.ir    = (st == 3'd1) ? ir : 1'($urandom_range(0, 1));
    c.dr    = (st == 3'd4) ? dr : 1'($urandom_range(0, 1));
    c.ad    = (st == 3'd3) ? ad : 1'($urandom_range(0, 1));
    c.halt  = rt ? cur_hlt : 1'($urandom_range(0, 1));
    c.start = (st == 3'd0) ? stt : 1'($urandom_range(0, 1));
    q.push_back(c);
  endfunction

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.imem_ready = c.ir;
      bus.dmem_ready = c.dr;
      bus.alu_done   = c.ad;
      bus.halt_req   = c.halt;
      bus.start      = c.start;
      @(negedge clk);
      check("state", 32'(bus.state), 32'(c.st));
      check("enables", 32'(en_vec()), 32'(c.en));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic leave_idle();
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) push(3'd0, 8'h00, 0, 0, 0, 0, 0);
      push(3'd0, 8'h00, 0, 0, 0, 0, 1);
      in_idle = 1'b0;
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input int iw, input int aw, input int dw,
                          input logic rw, input logic jp, input logic jl, input logic hlt);
    logic alu, ld, sto;
    logic [7:0] m;
    alu = (op == 4'h3) || (op == 4'h6);
    ld  = (op == 4'hC);
    sto = (op == 4'hD);
    cur_hlt = hlt;
    leave_idle();
    bus.opcode     = op;
    bus.reg_wr_dec = rw;
    bus.jump_dec   = jp;
    bus.jal_dec    = jl;
    for (int i = 0; i < iw; i++) push(3'd1, E_IREQ, 0, 0, 0, 0, 0);
    push(3'd1, E_IREQ | E_IRL, 1, 0, 0, 0, 0);
    if (op == 4'h0) begin
      push(3'd2, E_PC, 0, 0, 0, 1, 0);
    end else begin
      push(3'd2, 8'h00, 0, 0, 0, 0, 0);
      if (alu) begin
        for (int j = 0; j < aw; j++) push(3'd3, (j == 0) ? E_ALU : 8'h00, 0, 0, 0, 0, 0);
        push(3'd3, (aw == 0) ? E_ALU : 8'h00, 0, 0, 1, 0, 0);
      end else begin
        push(3'd3, 8'h00, 0, 0, 1'($urandom_range(0, 1)), 0, 0);
      end
      if (ld || sto) begin
        m = ld ? E_RD : E_WR;
        for (int k = 0; k < dw; k++) push(3'd4, m, 0, 0, 0, 0, 0);
        if (sto) push(3'd4, m | E_PC, 0, 1, 0, 1, 0);
        else     push(3'd4, m, 0, 1, 0, 0, 0);
      end
      if (!sto) push(3'd5, E_PC | (rw ? E_RF : 8'h00) | ((jp | jl) ? E_SEL : 8'h00), 0, 0, 0, 1, 0);
    end
    run_q();
    exp_cnt = exp_cnt + 1'b1;
    in_idle = hlt | STEP_MODE;
    check("retire_cnt", 32'(bus.retire_cnt), 32'(exp_cnt));
    check("err", 32'(bus.err), 32'd0);
    check("post_state", 32'(bus.state), in_idle ? 32'd0 : 32'd1);
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] op;
    case ($urandom_range(0, 4))
      0: op = 4'h0;
      1: op = ($urandom_range(0, 1) != 0) ? 4'h3 : 4'h6;
      2: op = 4'hC;
      3: op = 4'hD;
      default: begin
        op = 4'(($urandom_range(0, 15)));
        while (op == 4'h0 || op == 4'h3 || op == 4'h6 || op == 4'hC || op == 4'hD)
          op = 4'(($urandom_range(0, 15)));
      end
    endcase
    return op;
  endfunction

  task automatic reset_check(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_en"}, 32'(en_vec()), 32'd0);
    check({tag, "_cnt"}, 32'(bus.retire_cnt), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.halt_req = 0; bus.opcode = 4'h0; bus.reg_wr_dec = 0;
    bus.jump_dec = 0; bus.jal_dec = 0; bus.imem_ready = 0; bus.dmem_ready = 0; bus.alu_done = 0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step = 0;
`endif
    exp_cnt = '0;
    in_idle = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");
    rst = 1'b0;

    do_instr(4'h1, 0, 0, 0, 1, 0, 0, 0);
    do_instr(4'hC, 0, 0, 3, 1, 0, 0, 0);
    do_instr(4'hD, 0, 0, 0, 1, 1, 1, 0);
    do_instr(4'h6, 0, 5, 0, 1, 0, 0, 0);
    do_instr(4'hA, 0, 0, 0, 0, 1, 0, 1);
    do_instr(4'h0, 0, 0, 0, 1, 1, 0, 0);
    do_instr(4'h3, TO - 1, TO - 1, 0, 0, 0, 1, 0);
    do_instr(4'hC, 2, 0, TO - 1, 0, 0, 0, 1);
    for (int n = 0; n < 40; n++)
      do_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));

    cur_hlt = 1'b0;
    leave_idle();
    push(3'd1, E_IREQ, 0, 0, 0, 0, 0);
    push(3'd1, E_IREQ, 0, 0, 0, 0, 0);
    run_q();
    bus.imem_ready = 1'b1;
    rst = 1'b1;
    #1;
    reset_check("rst_mid_fetch");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    in_idle = 1'b1;

    leave_idle();
    for (int i = 0; i < TO; i++) push(3'd1, E_IREQ, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(3'd7, 8'h00, 0, 0, 0, 0, 0);
    run_q();
    check("timeout_err", 32'(bus.err), 32'd1);
    check("timeout_cnt", 32'(bus.retire_cnt), 32'd0);
    rst = 1'b1;
    #1;
    reset_check("rst_from_err");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
